// File: rtl/i3c_rx_pkg.sv
// Shared types and constants for the I3C SDR target receive front-end.
package i3c_rx_pkg;

  // Receive FSM states
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HDR  = 3'd1,
    ACK  = 3'd2,
    DATA = 3'd3,
    WAIT = 3'd4
  } rx_state_e;

  // Widest matched-slot index (NUM_ADDR up to 8 -> $clog2(8)+1 = 4 bits).
  localparam int IDX_MAX_W = 4;

  // One buffered receive entry
  typedef struct packed {
    logic [IDX_MAX_W-1:0] idx;
    logic [7:0]           data;
    logic                 perr;
  } rx_entry_t;

  // Reserved broadcast address; never a valid dynamic address.
  localparam logic [6:0] I3C_BCAST_ADDR = 7'h7E;
  // Data bits per private-write byte including the T-bit.
  localparam int         BITS_PER_DATA  = 9;

endpackage

// File: rtl/i3c_rx_fifo.sv
// Synchronous FIFO of rx_entry_t. Pointers advance by +1 and wrap naturally
// because FIFO_DEPTH is a power of two. A push while full is dropped unless
// a pop happens in the same cycle, which frees the slot first.
module i3c_rx_fifo
  import i3c_rx_pkg::*;
#(
  parameter int FIFO_DEPTH = 8
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      push_i,
  input  rx_entry_t push_data_i,
  input  logic      pop_i,
  output rx_entry_t head_o,
  output logic      full_o,
  output logic      empty_o,
  output logic      drop_o
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  rx_entry_t         mem_q [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [AW:0]       count_q;
  logic              do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (AW+1)'(FIFO_DEPTH));
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign drop_o  = push_i && full_o && !do_pop;
  assign head_o  = mem_q[rd_ptr_q];

  // Storage array: written on accepted push, not reset (guarded by empty_o)
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

  // Pointers and occupancy count
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/i3c_sdr_target_rx.sv
// Multi-address I3C SDR target receive front-end. Oversamples SCL/SDA,
// decodes START/Sr/STOP, ACKs private writes to any enabled dynamic
// address and buffers received bytes in a FIFO behind a valid/ready stream.
// Optional feature macro: I3C_RX_PARITY_CHECK_EN (T-bit odd-parity check).
//
// Stream handshake: m_valid_o stays high while the FIFO holds an entry and
// the head fields are stable; an entry is consumed in every cycle where
// m_valid_o && m_ready_i, and the next entry (if any) appears next cycle.
module i3c_sdr_target_rx
  import i3c_rx_pkg::*;
#(
  parameter int NUM_ADDR   = 2,
  parameter int FIFO_DEPTH = 8,
  parameter int IDX_W      = $clog2(NUM_ADDR) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  scl_i,
  input  logic                  sda_i,
  output logic                  sda_oe_o,
  input  logic [7*NUM_ADDR-1:0] dyn_addr_i,
  input  logic [NUM_ADDR-1:0]   addr_en_i,
  output logic                  m_valid_o,
  input  logic                  m_ready_i,
  output logic [7:0]            m_data_o,
  output logic [IDX_W-1:0]      m_idx_o,
  output logic                  m_perr_o,
  output logic                  frame_end_o,
  output logic                  ovf_o,
  input  logic                  ovf_clr_i,
  output rx_state_e             dbg_state_o
);

  localparam logic [3:0] LAST_HDR_BIT  = 4'd7;
  localparam logic [3:0] LAST_DATA_BIT = 4'(BITS_PER_DATA - 1);

  logic [1:0] scl_sync_q, sda_sync_q;
  logic       scl_prev_q, sda_prev_q;
  logic       scl_s, sda_s;
  logic       scl_rise, scl_fall, start_ev, stop_ev;

  rx_state_e              state_q;
  logic [3:0]             bit_cnt_q;
  logic [7:0]             shreg_q;
  logic [IDX_MAX_W-1:0]   match_idx_q;
  logic                   sda_oe_q;
  logic                   frame_end_q;
  logic                   ovf_q;

  logic                   hdr_hit;
  logic [IDX_MAX_W-1:0]   hit_idx;
  logic                   push;
  logic                   push_perr;
  rx_entry_t              push_entry, head;
  logic                   fifo_full, fifo_empty, fifo_drop;
  logic                   unused_head_bits;

  // Two-flop synchronizers plus previous-value registers; idle bus is high
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_sync_q <= 2'b11;
      sda_sync_q <= 2'b11;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[0], scl_i};
      sda_sync_q <= {sda_sync_q[0], sda_i};
      scl_prev_q <= scl_sync_q[1];
      sda_prev_q <= sda_sync_q[1];
    end
  end

  assign scl_s    = scl_sync_q[1];
  assign sda_s    = sda_sync_q[1];
  assign scl_rise =  scl_s && !scl_prev_q;
  assign scl_fall = !scl_s &&  scl_prev_q;
  // SDA edges only count as bus conditions while SCL is steadily high
  assign start_ev = scl_s && scl_prev_q &&  sda_prev_q && !sda_s;
  assign stop_ev  = scl_s && scl_prev_q && !sda_prev_q &&  sda_s;

  // Header match: write only, lowest enabled matching slot wins
  always_comb begin
    hdr_hit = 1'b0;
    hit_idx = '0;
    for (int k = NUM_ADDR - 1; k >= 0; k--) begin
      if (addr_en_i[k] && (dyn_addr_i[7*k +: 7] == shreg_q[6:0]) &&
          (shreg_q[6:0] != I3C_BCAST_ADDR)) begin
        hdr_hit = 1'b1;
        hit_idx = IDX_MAX_W'(k);
      end
    end
    if (sda_s) hdr_hit = 1'b0;
  end

  // Receive FSM with registered ACK drive and frame-end pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      shreg_q     <= '0;
      match_idx_q <= '0;
      sda_oe_q    <= 1'b0;
      frame_end_q <= 1'b0;
    end else begin
      frame_end_q <= 1'b0;
      if (stop_ev) begin
        frame_end_q <= (state_q == DATA);
        state_q     <= IDLE;
        sda_oe_q    <= 1'b0;
        bit_cnt_q   <= '0;
      end else if (start_ev) begin
        // START from IDLE or Sr from anywhere else; partial bytes are lost
        frame_end_q <= (state_q == DATA);
        state_q     <= HDR;
        sda_oe_q    <= 1'b0;
        bit_cnt_q   <= '0;
      end else begin
        case (state_q)
          HDR: begin
            if (scl_rise) begin
              shreg_q <= {shreg_q[6:0], sda_s};
              if (bit_cnt_q == LAST_HDR_BIT) begin
                bit_cnt_q <= '0;
                if (hdr_hit) begin
                  state_q     <= ACK;
                  match_idx_q <= hit_idx;
                end else begin
                  state_q <= WAIT;
                end
              end else begin
                bit_cnt_q <= bit_cnt_q + 1'b1;
              end
            end
          end
          ACK: begin
            // First fall (after RnW) starts the ACK, second fall ends it
            if (scl_fall) begin
              if (!sda_oe_q) begin
                sda_oe_q <= 1'b1;
              end else begin
                sda_oe_q  <= 1'b0;
                state_q   <= DATA;
                bit_cnt_q <= '0;
              end
            end
          end
          DATA: begin
            if (scl_rise) begin
              shreg_q <= {shreg_q[6:0], sda_s};
              if (bit_cnt_q == LAST_DATA_BIT) bit_cnt_q <= '0;
              else                            bit_cnt_q <= bit_cnt_q + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // On the T-bit rise the 8 data bits are in shreg_q and the T-bit is on sda_s
  assign push = (state_q == DATA) && scl_rise && (bit_cnt_q == LAST_DATA_BIT);

`ifdef I3C_RX_PARITY_CHECK_EN
  assign push_perr = ~(^{shreg_q, sda_s});
`else
  assign push_perr = 1'b0;
`endif

  assign push_entry = '{idx: match_idx_q, data: shreg_q, perr: push_perr};

  i3c_rx_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push),
    .push_data_i (push_entry),
    .pop_i       (m_valid_o && m_ready_i),
    .head_o      (head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .drop_o      (fifo_drop)
  );

  // Sticky overflow: a drop in the same cycle as a clear keeps the flag set
  always_ff @(posedge clk) begin
    if (rst)            ovf_q <= 1'b0;
    else if (fifo_drop) ovf_q <= 1'b1;
    else if (ovf_clr_i) ovf_q <= 1'b0;
  end

  assign sda_oe_o    = sda_oe_q;
  assign frame_end_o = frame_end_q;
  assign ovf_o       = ovf_q;
  assign dbg_state_o = state_q;
  assign m_valid_o   = !fifo_empty;
  assign m_data_o    = fifo_empty ? 8'h00 : head.data;
  assign m_idx_o     = fifo_empty ? '0 : head.idx[IDX_W-1:0];
`ifdef I3C_RX_PARITY_CHECK_EN
  assign m_perr_o    = fifo_empty ? 1'b0 : head.perr;
`else
  assign m_perr_o    = 1'b0;
`endif
  assign unused_head_bits = ^{head.idx, head.perr, fifo_full};

endmodule

// File: tb/tb_i3c_sdr_target_rx.sv
// Self-checking bench for i3c_sdr_target_rx (NUM_ADDR=2, FIFO_DEPTH=4).
// Honours I3C_RX_PARITY_CHECK_EN for the expected T-bit error flag.
`timescale 1ns/1ps
module tb_i3c_sdr_target_rx;
  import i3c_rx_pkg::*;

  localparam int NUM_ADDR   = 2;
  localparam int FIFO_DEPTH = 4;
  localparam int IDX_W      = 2;
`ifdef I3C_RX_PARITY_CHECK_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  scl_m, sda_m, sda_bus;
  logic                  sda_oe_o;
  logic [7*NUM_ADDR-1:0] dyn_addr;
  logic [NUM_ADDR-1:0]   addr_en;
  logic                  m_valid_o, m_ready_i;
  logic [7:0]            m_data_o;
  logic [IDX_W-1:0]      m_idx_o;
  logic                  m_perr_o, frame_end_o, ovf_o, ovf_clr_i;
  rx_state_e             dbg_state;

  // Clock / open-drain bus
  always #5 clk = ~clk;
  assign sda_bus = sda_m & ~sda_oe_o;

  i3c_sdr_target_rx #(
    .NUM_ADDR   (NUM_ADDR),
    .FIFO_DEPTH (FIFO_DEPTH),
    .IDX_W      (IDX_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .scl_i       (scl_m),
    .sda_i       (sda_bus),
    .sda_oe_o    (sda_oe_o),
    .dyn_addr_i  (dyn_addr),
    .addr_en_i   (addr_en),
    .m_valid_o   (m_valid_o),
    .m_ready_i   (m_ready_i),
    .m_data_o    (m_data_o),
    .m_idx_o     (m_idx_o),
    .m_perr_o    (m_perr_o),
    .frame_end_o (frame_end_o),
    .ovf_o       (ovf_o),
    .ovf_clr_i   (ovf_clr_i),
    .dbg_state_o (dbg_state)
  );

  int          tests = 0;
  int          fails = 0;
  logic [12:0] exp_q[$];     // {idx[3:0], data[7:0], perr}
  logic [12:0] last_pop;
  int          fe_cnt = 0;
  int          cur_idx = -1; // model's matched slot for the current frame

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model: which slot (if any) accepts this header
  function automatic int model_match(logic [6:0] a, bit rnw);
    if (rnw || a == 7'h7E) return -1;
    for (int k = 0; k < NUM_ADDR; k++)
      if (addr_en[k] && dyn_addr[7*k +: 7] == a) return k;
    return -1;
  endfunction

  // Model: enqueue a byte as the consumer must later see it
  task automatic model_push(int idx, logic [7:0] d, bit t);
    logic perr;
    perr = PAR_EN ? ~(^{d, t}) : 1'b0;
    if (exp_q.size() < FIFO_DEPTH) exp_q.push_back({4'(idx), d, perr});
  endtask

  function automatic bit good_t(logic [7:0] d);
    return ~(^d);
  endfunction

  // Scoreboard: every handshake must match the model's head entry
  always @(negedge clk) begin
    logic [12:0] w;
    logic [12:0] e;
    if (!rst) begin
      if (frame_end_o) fe_cnt++;
      if (m_valid_o && m_ready_i) begin
        w = {2'b00, m_idx_o, m_data_o, m_perr_o};
        last_pop = w;
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL pop_unexpected: got %0h expected no entry", w);
        end else begin
          e = exp_q.pop_front();
          check("pop_entry", w, e);
        end
      end
    end
  end

  // Driver tasks
  task automatic clks(int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic send_bit(bit b);
    sda_m = b; clks(4); scl_m = 1'b1; clks(8); scl_m = 1'b0; clks(4);
  endtask

  task automatic bus_start();
    sda_m = 1'b1; clks(4); scl_m = 1'b1; clks(8); sda_m = 1'b0; clks(8);
    scl_m = 1'b0; clks(4);
    cur_idx = -1;
  endtask

  task automatic bus_stop();
    sda_m = 1'b0; clks(4); scl_m = 1'b1; clks(8); sda_m = 1'b1; clks(8);
  endtask

  task automatic send_hdr_bits(logic [6:0] a, bit rnw);
    logic [7:0] h;
    h = {a, rnw};
    for (int i = 7; i >= 0; i--) send_bit(h[i]);
    cur_idx = model_match(a, rnw);
  endtask

  task automatic ack_bit(string name);
    logic seen;
    sda_m = 1'b1; clks(4); scl_m = 1'b1; clks(4);
    #1 seen = ~sda_bus;
    check(name, seen, cur_idx >= 0);
    clks(4); scl_m = 1'b0; clks(4);
  endtask

  task automatic send_data(logic [7:0] d, bit t);
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
    sda_m = t; clks(4); scl_m = 1'b1;
    if (cur_idx >= 0) model_push(cur_idx, d, t);
    clks(8); scl_m = 1'b0; clks(4);
  endtask

  task automatic frame(logic [6:0] a, logic [7:0] d, bit t, string name);
    bus_start(); send_hdr_bits(a, 1'b0); ack_bit(name); send_data(d, t); bus_stop();
  endtask

  // Watchdog
  initial begin
    #500us;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int fe0;
    int n;
    rst = 1'b1; scl_m = 1'b1; sda_m = 1'b1; m_ready_i = 1'b0; ovf_clr_i = 1'b0;
    dyn_addr = {7'h2A, 7'h15};
    addr_en  = 2'b11;
    clks(3);
    #1;
    check("rst_sda_oe", sda_oe_o, 0);
    check("rst_valid", m_valid_o, 0);
    check("rst_data", m_data_o, 0);
    check("rst_idx", m_idx_o, 0);
    check("rst_perr", m_perr_o, 0);
    check("rst_frame_end", frame_end_o, 0);
    check("rst_ovf", ovf_o, 0);
    rst = 1'b0;
    clks(4);

    // Basic write to slot 1 (header 8'h54), byte A5 T=1
    frame(7'h2A, 8'hA5, 1'b1, "ack_slot1");
    clks(4); #1;
    check("t1_valid", m_valid_o, 1);
    check("t1_data", m_data_o, 8'hA5);
    check("t1_idx", m_idx_o, 1);
    check("t1_perr", m_perr_o, 0);
    check("t1_frame_end_cnt", fe_cnt, 1);
    m_ready_i = 1'b1;
    clks(3);
    check("t1_drained", m_valid_o, 0);

    // Unmatched address and read header: no ACK, no data, no frame end
    fe0 = fe_cnt;
    bus_start(); send_hdr_bits(7'h33, 1'b0); ack_bit("nack_33");
    send_data(8'h12, 1'b1); send_data(8'h34, 1'b0); send_data(8'h56, 1'b1);
    bus_stop();
    bus_start(); send_hdr_bits(7'h2A, 1'b1); ack_bit("nack_rnw");
    send_data(8'h77, 1'b0); bus_stop();
    clks(4);
    check("t2_frame_end", fe_cnt, fe0);
    check("t2_valid", m_valid_o, 0);

    // Bad parity byte 0F with T=0
    m_ready_i = 1'b0;
    frame(7'h15, 8'h0F, 1'b0, "ack_slot0");
    clks(4); #1;
    check("t3_data", m_data_o, 8'h0F);
    check("t3_perr", m_perr_o, PAR_EN);
    m_ready_i = 1'b1;
    clks(3);

    // Overflow: six bytes into a four-entry FIFO with consumer stalled
    m_ready_i = 1'b0;
    bus_start(); send_hdr_bits(7'h2A, 1'b0); ack_bit("ack_ovf");
    for (int i = 0; i < 6; i++) send_data(8'h81 + 8'(i), good_t(8'h81 + 8'(i)));
    bus_stop();
    clks(2); #1;
    check("t4_ovf_set", ovf_o, 1);
    check("t4_head", m_data_o, 8'h81);
    check("t4_model_depth", exp_q.size(), 4);
    ovf_clr_i = 1'b1; clks(1); #1; ovf_clr_i = 1'b0;
    check("t4_ovf_clr", ovf_o, 0);
    m_ready_i = 1'b1;
    clks(8);
    check("t4_last", last_pop, {4'd1, 8'h84, 1'b0});
    check("t4_empty", m_valid_o, 0);
    check("t4_model_empty", exp_q.size(), 0);

    // Sr after four data bits, then slot 0 with byte 11
    fe0 = fe_cnt;
    bus_start(); send_hdr_bits(7'h2A, 1'b0); ack_bit("ack_pre_sr");
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
    bus_start(); send_hdr_bits(7'h15, 1'b0); ack_bit("ack_post_sr");
    check("t5_frame_end_sr", fe_cnt, fe0 + 1);
    send_data(8'h11, good_t(8'h11)); bus_stop();
    clks(4);
    check("t5_frame_end_total", fe_cnt, fe0 + 2);
    check("t5_entry", last_pop, {4'd0, 8'h11, 1'b0});

    // Both slots share an address: lowest index wins
    dyn_addr = {7'h15, 7'h15};
    frame(7'h15, 8'h5A, good_t(8'h5A), "ack_dup");
    clks(4);
    check("t6_lowest_idx", last_pop, {4'd0, 8'h5A, 1'b0});
    dyn_addr = {7'h2A, 7'h15};

    // Reset while ACK is being driven
    bus_start(); send_hdr_bits(7'h2A, 1'b0);
    n = 0;
    while (!sda_oe_o && n < 40) begin clks(1); n++; end
    check("t7_oe_before_rst", sda_oe_o, 1);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    check("t7_oe_released", sda_oe_o, 0);
    check("t7_fifo_empty", m_valid_o, 0);
    @(negedge clk); rst = 1'b0;
    cur_idx = -1;
    exp_q.delete();
    bus_stop();
    fe0 = fe_cnt;
    frame(7'h2A, 8'h3C, good_t(8'h3C), "ack_after_rst");
    clks(4);
    check("t7_entry", last_pop, {4'd1, 8'h3C, 1'b0});
    check("t7_frame_end", fe_cnt, fe0 + 1);
    check("t7_model_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
